// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Memory-side responder for the pipeline's two memory initiators.
//            The IF port is read-only and the MEM port is read/write. Both
//            share one physical-memory port. Each initiator holds its request
//            until it sees its one-cycle resp pulse.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            if_*                  - IF initiator (read only)
//            mem_*                 - MEM initiator (read/write)
//            pmem_*                - physical memory / cache port
// Config   : ARB_ROUND_ROBIN_EN    - defined: round-robin tie-break
//                                    undefined: fixed D priority with a
//                                    starvation counter (STARVE_MAX)
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // IF initiator
  input  logic [ADDR_W-1:0] if_memaddr,
  input  logic              if_memread,
  input  logic [1:0]        if_mem_byte_enable,
  output logic [DATA_W-1:0] if_mem_rdata,
  output logic              if_mem_resp,
  // MEM initiator
  input  logic [ADDR_W-1:0] mem_memaddr,
  input  logic              mem_memread,
  input  logic              mem_memwrite,
  input  logic [1:0]        mem_mem_byte_enable,
  input  logic [DATA_W-1:0] mem_mem_wdata,
  output logic [DATA_W-1:0] mem_mem_rdata,
  output logic              mem_mem_resp,
  // Physical memory
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_byte_enable,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_BUSY = 3'd1,
    ST_D_BUSY = 3'd2,
    ST_I_DONE = 3'd3,
    ST_D_DONE = 3'd4
  } state_t;

  state_t r_state;
  logic   r_abort;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic c_PORT_I = 1'b0;
  localparam logic c_PORT_D = 1'b1;
  logic r_rr_last;
  // Clear until the first grant after reset, so the very first tie still
  // goes to D; from then on ties alternate against r_rr_last.
  logic r_rr_seen;
`else
  localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
  logic [c_CNT_W-1:0] r_starve_cnt;
`endif

  logic w_req_i;
  logic w_req_d;
  logic w_req_any;
  logic w_grant_d;
  logic w_owner_drop;
  logic w_abort_nxt;

  assign w_req_i   = if_memread;
  assign w_req_d   = mem_memread | mem_memwrite;
  assign w_req_any = w_req_i | w_req_d;

  // Owner withdrawing its request mid-transaction (e.g. pipeline flush).
  // Also looked at in the pmem_resp cycle so a same-cycle drop suppresses resp.
  assign w_owner_drop = ((r_state == ST_I_BUSY) && !w_req_i) ||
                        ((r_state == ST_D_BUSY) && !w_req_d);
  assign w_abort_nxt  = r_abort | w_owner_drop;

  // Winner selection; only meaningful in IDLE with at least one request.
  always_comb begin
    w_grant_d = w_req_d;
    if (w_req_i && w_req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_grant_d = !r_rr_seen || (r_rr_last == c_PORT_I);
`else
      w_grant_d = (r_starve_cnt != c_STARVE_MAX);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_abort          <= 1'b0;
      if_mem_rdata     <= '0;
      if_mem_resp      <= 1'b0;
      mem_mem_rdata    <= '0;
      mem_mem_resp     <= 1'b0;
      pmem_address     <= '0;
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= '0;
      pmem_wdata       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_rr_last        <= c_PORT_D;
      r_rr_seen        <= 1'b0;
`else
      r_starve_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_abort <= 1'b0;
            if (w_grant_d) begin
              r_state          <= ST_D_BUSY;
              pmem_address     <= mem_memaddr;
              // read+write together is treated as a write
              pmem_read        <= ~mem_memwrite;
              pmem_write       <= mem_memwrite;
              pmem_byte_enable <= mem_mem_byte_enable;
              pmem_wdata       <= mem_mem_wdata;
            end else begin
              r_state          <= ST_I_BUSY;
              pmem_address     <= if_memaddr;
              pmem_read        <= 1'b1;
              pmem_write       <= 1'b0;
              pmem_byte_enable <= if_mem_byte_enable;
              pmem_wdata       <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_last <= w_grant_d ? c_PORT_D : c_PORT_I;
            r_rr_seen <= 1'b1;
`endif
          end
        end

        ST_I_BUSY, ST_D_BUSY: begin
          // pmem_* stay frozen from the grant-time copies until completion.
          r_abort <= w_abort_nxt;
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            r_abort    <= 1'b0;
            if (w_abort_nxt) begin
              r_state <= ST_IDLE;
            end else if (r_state == ST_I_BUSY) begin
              r_state      <= ST_I_DONE;
              if_mem_resp  <= 1'b1;
              if_mem_rdata <= pmem_rdata;
            end else begin
              r_state       <= ST_D_DONE;
              mem_mem_resp  <= 1'b1;
              mem_mem_rdata <= pmem_write ? '0 : pmem_rdata;
            end
          end
        end

        ST_I_DONE, ST_D_DONE: begin
          if_mem_resp   <= 1'b0;
          if_mem_rdata  <= '0;
          mem_mem_resp  <= 1'b0;
          mem_mem_rdata <= '0;
          r_state       <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase

`ifndef ARB_ROUND_ROBIN_EN
      // Count D grants that bypass a waiting I; any I grant or an idle I clears.
      if (!w_req_i) begin
        r_starve_cnt <= '0;
      end else if ((r_state == ST_IDLE) && w_req_any) begin
        if (!w_grant_d) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire
